// File: rtl/lc4_regfile_ss_if.sv
// Port bundle for the dual-issue LC4 register file: read selectors/data, two write ports,
// scoreboard claim and busy vector. master = datapath side, slave = register file.
interface lc4_regfile_ss_if #(
  parameter int n     = 16,
  parameter int SEL_W = 3
);
  localparam int NREG = 2 ** SEL_W;

  logic             gwe;
  logic [SEL_W-1:0] i_rs_a;
  logic [n-1:0]     o_rs_a_data;
  logic [SEL_W-1:0] i_rt_a;
  logic [n-1:0]     o_rt_a_data;
  logic [SEL_W-1:0] i_rs_b;
  logic [n-1:0]     o_rs_b_data;
  logic [SEL_W-1:0] i_rt_b;
  logic [n-1:0]     o_rt_b_data;
  logic [SEL_W-1:0] i_rd_a;
  logic [n-1:0]     i_wdata_a;
  logic             i_rd_we_a;
  logic [SEL_W-1:0] i_rd_b;
  logic [n-1:0]     i_wdata_b;
  logic             i_rd_we_b;
  logic [SEL_W-1:0] i_claim_rd;
  logic             i_claim_we;
  logic [NREG-1:0]  o_busy;

  modport master (
    output gwe, i_rs_a, i_rt_a, i_rs_b, i_rt_b,
    output i_rd_a, i_wdata_a, i_rd_we_a, i_rd_b, i_wdata_b, i_rd_we_b,
    output i_claim_rd, i_claim_we,
    input  o_rs_a_data, o_rt_a_data, o_rs_b_data, o_rt_b_data, o_busy
  );

  modport slave (
    input  gwe, i_rs_a, i_rt_a, i_rs_b, i_rt_b,
    input  i_rd_a, i_wdata_a, i_rd_we_a, i_rd_b, i_wdata_b, i_rd_we_b,
    input  i_claim_rd, i_claim_we,
    output o_rs_a_data, o_rt_a_data, o_rs_b_data, o_rt_b_data, o_busy
  );
endinterface

// File: rtl/lc4_regfile_ss.sv
// Dual-issue LC4 register file with busy scoreboard; reads are zero-latency, writes/busy land at posedge when gwe=1.
// No backpressure. Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports (B > A > stored).
module lc4_regfile_ss #(
  parameter int n     = 16,
  parameter int SEL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  lc4_regfile_ss_if.slave   rf
);
  localparam int NREG  = 2 ** SEL_W;
  localparam int NPORT = 4;

  logic [n-1:0]     regs [NREG];
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_nxt;
  logic             wr_a_en;
  logic [SEL_W-1:0] rd_sel  [NPORT];
  logic [n-1:0]     rd_data [NPORT];

  // The younger instruction (port B) owns a colliding destination, so A is suppressed.
  assign wr_a_en = rf.i_rd_we_a && !(rf.i_rd_we_b && (rf.i_rd_a == rf.i_rd_b));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREG; k++) begin
        regs[k] <= '0;
      end
      busy <= '0;
    end else if (rf.gwe) begin
      if (wr_a_en) begin
        regs[rf.i_rd_a] <= rf.i_wdata_a;
      end
      if (rf.i_rd_we_b) begin
        regs[rf.i_rd_b] <= rf.i_wdata_b;
      end
      busy <= busy_nxt;
    end
  end

  // Writeback releases, decode claims; a claim is applied last so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NREG; k++) begin
      if (rf.i_rd_we_a && (rf.i_rd_a == SEL_W'(k))) begin
        busy_nxt[k] = 1'b0;
      end
      if (rf.i_rd_we_b && (rf.i_rd_b == SEL_W'(k))) begin
        busy_nxt[k] = 1'b0;
      end
      if (rf.i_claim_we && (rf.i_claim_rd == SEL_W'(k))) begin
        busy_nxt[k] = 1'b1;
      end
    end
  end

  assign rd_sel[0] = rf.i_rs_a;
  assign rd_sel[1] = rf.i_rt_a;
  assign rd_sel[2] = rf.i_rs_b;
  assign rd_sel[3] = rf.i_rt_b;

  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      rd_data[p] = regs[rd_sel[p]];
`ifdef REGFILE_BYPASS_EN
      if (rf.i_rd_we_a && (rf.i_rd_a == rd_sel[p])) begin
        rd_data[p] = rf.i_wdata_a;
      end
      if (rf.i_rd_we_b && (rf.i_rd_b == rd_sel[p])) begin
        rd_data[p] = rf.i_wdata_b;
      end
`endif
    end
  end

  assign rf.o_rs_a_data = rd_data[0];
  assign rf.o_rt_a_data = rd_data[1];
  assign rf.o_rs_b_data = rd_data[2];
  assign rf.o_rt_b_data = rd_data[3];
  assign rf.o_busy      = busy;
endmodule
